// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with runtime bit period feeding a first-word fall-through FIFO.
// Sticky overrun/framing flags; level interrupt while bytes are waiting.
module uart_rx_fifo #(
  parameter int FIFO_AW = 4,
  parameter int CPB_W   = 12
) (
  input  logic               i_Clk,
  input  logic               i_Rst_L,
  input  logic [CPB_W-1:0]   i_Clk_per_bit,
  input  logic               i_RX_Serial,
  input  logic               i_Rd_En,
  input  logic               i_Clr_Err,
  output logic [7:0]         o_RX_Byte,
  output logic               o_Empty,
  output logic               o_Full,
  output logic [FIFO_AW:0]   o_Count,
  output logic               o_Overrun,
  output logic               o_Frame_Err,
  output logic               o_Irq
);

  localparam int DEPTH = 1 << FIFO_AW;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  localparam logic [CPB_W-1:0] CPB_ONE = CPB_W'(1);
  localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW + 1)'(1);

  logic [1:0]         sync_q;
  logic               rx_s;
  logic [2:0]         state_q, state_d;
  logic [CPB_W-1:0]   cpb_q, cpb_d;
  logic [CPB_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         shift_q, shift_d;
  logic [CPB_W-1:0]   half_m1, bit_m1;
  logic               push, frame_set;

  logic [FIFO_AW:0]   wr_ptr_q, rd_ptr_q, count_q;
  logic               overrun_q, frame_err_q;
  logic [7:0]         mem [DEPTH];
  logic               empty, full, pop, wr_en, overrun_set;

  assign rx_s    = sync_q[1];
  assign half_m1 = (cpb_q >> 1) - CPB_ONE;
  assign bit_m1  = cpb_q - CPB_ONE;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cpb_d     = cpb_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          cpb_d   = i_Clk_per_bit;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == half_m1) begin
          if (!rx_s) begin
            state_d = S_DATA;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CPB_ONE;
        end
      end
      S_DATA: begin
        if (cnt_q == bit_m1) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CPB_ONE;
        end
      end
      S_STOP: begin
        if (cnt_q == bit_m1) begin
          cnt_d = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = S_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CPB_ONE;
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                       (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign pop         = i_Rd_En && !empty;
  assign wr_en       = push && (!full || pop);
  assign overrun_set = push && full && !pop;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sync_q      <= 2'b11;
      state_q     <= S_IDLE;
      cpb_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], i_RX_Serial};
      state_q <= state_d;
      cpb_q   <= cpb_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + PTR_ONE;
        2'b01:   count_q <= count_q - PTR_ONE;
        default: count_q <= count_q;
      endcase
      // A new error outranks a clear arriving in the same cycle.
      if (overrun_set)    overrun_q <= 1'b1;
      else if (i_Clr_Err) overrun_q <= 1'b0;
      if (frame_set)      frame_err_q <= 1'b1;
      else if (i_Clr_Err) frame_err_q <= 1'b0;
    end
  end

  // NOTE: the storage array is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge i_Clk) begin
    if (i_Rst_L && wr_en) mem[wr_ptr_q[FIFO_AW-1:0]] <= shift_q;
  end

  assign o_RX_Byte   = empty ? 8'h00 : mem[rd_ptr_q[FIFO_AW-1:0]];
  assign o_Empty     = empty;
  assign o_Full      = full;
  assign o_Irq       = ~empty;
  assign o_Count     = count_q;
  assign o_Overrun   = overrun_q;
  assign o_Frame_Err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: serial frames are driven on the line and
// expected bytes are queued, then compared against the FIFO head on each pop.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic [11:0] cpb = 12'd16;
  logic        rx = 1'b1;
  logic        rd_en = 1'b0;
  logic        clr_err = 1'b0;
  logic [7:0]  rx_byte;
  logic        empty, full, overrun, frame_err, irq;
  logic [4:0]  count;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo #(.FIFO_AW(4), .CPB_W(12)) dut (
    .i_Clk(clk), .i_Rst_L(rst_l), .i_Clk_per_bit(cpb), .i_RX_Serial(rx),
    .i_Rd_En(rd_en), .i_Clr_Err(clr_err), .o_RX_Byte(rx_byte), .o_Empty(empty),
    .o_Full(full), .o_Count(count), .o_Overrun(overrun), .o_Frame_Err(frame_err),
    .o_Irq(irq)
  );

  always #5 clk = ~clk;

  // Called at a falling edge; leaves the line idle high on return.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int low_tail);
    rx = 1'b0;
    repeat (int'(cpb)) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (int'(cpb)) @(negedge clk);
    end
    rx = stop_bit;
    repeat (int'(cpb)) @(negedge clk);
    if (low_tail > 0) begin
      rx = 1'b0;
      repeat (low_tail * int'(cpb)) @(negedge clk);
      rx = 1'b1;
      repeat (int'(cpb)) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic pop_check(input string name);
    logic [7:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: scoreboard empty, DUT head=%02h", name, rx_byte);
    end else begin
      e = exp_q.pop_front();
      if (rx_byte !== e) begin
        miscompares++;
        $display("FAIL %s: o_RX_Byte=%02h expected %02h", name, rx_byte, e);
      end
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({empty, irq, full, overrun, frame_err} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_flags: {empty,irq,full,ovr,ferr}=%b expected 10000",
               {empty, irq, full, overrun, frame_err});
    end
    vectors++;
    if ({count, rx_byte} !== 13'h0) begin
      miscompares++;
      $display("FAIL reset_data: count=%0d byte=%02h expected 0/00", count, rx_byte);
    end
    rst_l = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    int lat = 0;
    int lo, hi;
    cpb = 12'd3333;
    lo = 9 * 3333 + (3333 >> 1);
    hi = lo + 4;
    exp_q.push_back(8'hAF);
    fork
      send_byte(8'hAF, 1'b1, 0);
      begin
        while (count == 5'd0 && lat < 11 * 3333) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    vectors++;
    if (lat < lo || lat > hi) begin
      miscompares++;
      $display("FAIL single_latency: %0d clks expected %0d..%0d", lat, lo, hi);
    end
    vectors++;
    if ({count, irq} !== {5'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL single_count: count=%0d irq=%b expected 1/1", count, irq);
    end
    pop_check("single_byte");
    vectors++;
    if ({empty, irq} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_drain: empty=%b irq=%b expected 1/0", empty, irq);
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    vectors++;
    if ({count, empty, rx_byte} !== {5'd0, 1'b1, 8'h00}) begin
      miscompares++;
      $display("FAIL underflow: count=%0d empty=%b byte=%02h expected 0/1/00",
               count, empty, rx_byte);
    end
    cpb = 12'd16;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [4];
    seq[0] = 8'hAF; seq[1] = 8'hCD; seq[2] = 8'h54; seq[3] = 8'hEB;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(seq[i]);
      send_byte(seq[i], 1'b1, 0);
    end
    vectors++;
    if ({count, overrun, frame_err} !== {5'd4, 2'b00}) begin
      miscompares++;
      $display("FAIL b2b_count: count=%0d ovr=%b ferr=%b expected 4/0/0",
               count, overrun, frame_err);
    end
    for (int i = 0; i < 4; i++) pop_check("b2b_order");
    vectors++;
    if (empty !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_empty: empty=%b expected 1", empty);
    end
  endtask

  task automatic test_overflow();
    int k;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1, 0);
    end
    vectors++;
    if ({full, overrun, count} !== {2'b11, 5'd16}) begin
      miscompares++;
      $display("FAIL overflow_flags: full=%b ovr=%b count=%0d expected 1/1/16",
               full, overrun, count);
    end
    pulse_clr();
    vectors++;
    if ({overrun, full} !== 2'b01) begin
      miscompares++;
      $display("FAIL overflow_clr: ovr=%b full=%b expected 0/1", overrun, full);
    end
    // Pop exactly in the cycle the next byte is pushed into the full FIFO.
    k = 9 * int'(cpb) + (int'(cpb) >> 1) + 3;
    fork
      send_byte(8'h10, 1'b1, 0);
      begin
        repeat (k - 1) @(negedge clk);
        pop_check("full_push_pop_head");
      end
    join
    exp_q.push_back(8'h10);
    vectors++;
    if ({count, overrun, full} !== {5'd16, 2'b01}) begin
      miscompares++;
      $display("FAIL full_push_pop: count=%0d ovr=%b full=%b expected 16/0/1",
               count, overrun, full);
    end
    for (int i = 0; i < 16; i++) pop_check("overflow_contents");
    vectors++;
    if ({empty, full} !== 2'b10) begin
      miscompares++;
      $display("FAIL overflow_drain: empty=%b full=%b expected 1/0", empty, full);
    end
  endtask

  task automatic test_frame_err();
    send_byte(8'h55, 1'b0, 3);
    vectors++;
    if ({frame_err, count} !== {1'b1, 5'd0}) begin
      miscompares++;
      $display("FAIL frame_err: ferr=%b count=%0d expected 1/0", frame_err, count);
    end
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1, 0);
    vectors++;
    if ({count, frame_err} !== {5'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL frame_recover: count=%0d ferr=%b expected 1/1", count, frame_err);
    end
    pop_check("frame_next_byte");
    pulse_clr();
    vectors++;
    if (frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_clr: ferr=%b expected 0", frame_err);
    end
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    repeat (int'(cpb) / 4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * int'(cpb)) @(negedge clk);
    vectors++;
    if ({count, frame_err, overrun} !== 7'd0) begin
      miscompares++;
      $display("FAIL glitch: count=%0d ferr=%b ovr=%b expected 0/0/0",
               count, frame_err, overrun);
    end
    exp_q.push_back(8'h96);
    send_byte(8'h96, 1'b1, 0);
    pop_check("glitch_next_byte");
  endtask

  task automatic test_reset_mid();
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b1, 0);
    exp_q.push_back(8'h34);
    send_byte(8'h34, 1'b1, 0);
    rx = 1'b0;
    repeat (int'(cpb)) @(negedge clk);
    rx = 1'b1;
    repeat (2 * int'(cpb)) @(negedge clk);
    rst_l = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    exp_q.delete();
    vectors++;
    if ({count, empty, irq} !== {5'd0, 2'b10}) begin
      miscompares++;
      $display("FAIL reset_mid: count=%0d empty=%b irq=%b expected 0/1/0",
               count, empty, irq);
    end
    repeat (2 * int'(cpb)) @(negedge clk);
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, 0);
    vectors++;
    if (count !== 5'd1) begin
      miscompares++;
      $display("FAIL reset_mid_recv: count=%0d expected 1", count);
    end
    pop_check("reset_mid_byte");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover: %0d bytes never popped", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
